segvect_match_resolver: RTL and testbench

Pipelined resolver directly downstream of the segment vector memory (`segvectmemx`). It takes the `VTWID`-bit segment vector read out for a search key. The vector has one `SEGWID`-bit entry per `DWID`-bit key segment. The resolver reduces the vector to a single match/miss/conflict verdict with a rule ID. It also keeps saturating hit/miss statistics for the lookup path.

---
 rtl/segvect_match_resolver.sv | 129 ++++++++++++
 tb/tb_segvect_match_resolver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/segvect_match_resolver.sv
// Two-stage resolver that reduces a segment vector to a match/conflict verdict with a rule ID.
// Stage 1 registers per-segment flags. Stage 2 registers the verdict. Hit/miss counters saturate.
module segvect_match_resolver #(
  parameter int unsigned KWID   = 104,
  parameter int unsigned DWID   = 8,
  parameter int unsigned SEGWID = DWID + 2,
  parameter int unsigned NSEG   = KWID / DWID,
  parameter int unsigned VTWID  = SEGWID * NSEG,
  parameter int unsigned CWID   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [VTWID-1:0] in_vec,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_match,
  output logic             out_conflict,
  output logic [DWID-1:0]  out_id,
  input  logic             cnt_clr,
  output logic [CWID-1:0]  hit_cnt,
  output logic [CWID-1:0]  miss_cnt
);

  localparam logic [CWID-1:0] CntOne = CWID'(1);

  logic            w_adv;
  logic            w_fire;
  logic [NSEG-1:0] w_cov;
  logic [NSEG-1:0] w_con;
  logic [DWID-1:0] w_id [NSEG];
  logic            w_all_cov;
  logic            w_any_con;
  logic            w_same;
  logic [DWID-1:0] w_ref_id;

  logic            r_s1_vld;
  logic [NSEG-1:0] r_s1_cov;
  logic [NSEG-1:0] r_s1_con;
  logic [DWID-1:0] r_s1_id [NSEG];
  logic            r_out_vld;
  logic            r_out_match;
  logic            r_out_conflict;
  logic [DWID-1:0] r_out_id;
  logic [CWID-1:0] r_hit_cnt;
  logic [CWID-1:0] r_miss_cnt;

  // A single enable for both stages keeps the pipeline free of internal skid state.
  assign w_adv  = !r_out_vld || out_rdy;
  assign w_fire = r_out_vld && out_rdy;
  assign in_rdy = w_adv;

  always_comb begin
    w_cov = '0;
    w_con = '0;
    for (int s = 0; s < int'(NSEG); s++) begin
      w_cov[s] = in_vec[s*SEGWID+DWID] | in_vec[s*SEGWID+DWID+1];
      w_con[s] = in_vec[s*SEGWID+DWID] & ~in_vec[s*SEGWID+DWID+1];
      w_id[s]  = in_vec[s*SEGWID +: DWID];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld <= 1'b0;
      r_s1_cov <= '0;
      r_s1_con <= '0;
      for (int s = 0; s < int'(NSEG); s++) r_s1_id[s] <= '0;
    end else if (w_adv) begin
      r_s1_vld <= in_vld;
      r_s1_cov <= w_cov;
      r_s1_con <= w_con;
      for (int s = 0; s < int'(NSEG); s++) r_s1_id[s] <= w_id[s];
    end
  end

  // Scanning downward leaves the lowest-index contributing ID as the reference.
  always_comb begin
    w_all_cov = &r_s1_cov;
    w_any_con = |r_s1_con;
    w_ref_id  = '0;
    for (int s = int'(NSEG) - 1; s >= 0; s--) begin
      if (r_s1_con[s]) w_ref_id = r_s1_id[s];
    end
    w_same = 1'b1;
    for (int s = 0; s < int'(NSEG); s++) begin
      if (r_s1_con[s] && (r_s1_id[s] != w_ref_id)) w_same = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_vld      <= 1'b0;
      r_out_match    <= 1'b0;
      r_out_conflict <= 1'b0;
      r_out_id       <= '0;
    end else if (w_adv) begin
      r_out_vld      <= r_s1_vld;
      r_out_match    <= w_all_cov & w_any_con & w_same;
      r_out_conflict <= w_all_cov & w_any_con & ~w_same;
      r_out_id       <= w_ref_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_fire) begin
      if (r_out_match) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CntOne;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CntOne;
      end
    end
  end

  assign out_vld      = r_out_vld;
  assign out_match    = r_out_match;
  assign out_conflict = r_out_conflict;
  assign out_id       = r_out_id;
  assign hit_cnt      = r_hit_cnt;
  assign miss_cnt     = r_miss_cnt;

endmodule

// File: tb/tb_segvect_match_resolver.sv
// Directed bench for segvect_match_resolver: vector table, stall stream, saturation, clear, reset.
// Counters are built 4 bits wide so saturation is reachable in a few cycles.
module tb_segvect_match_resolver;

  localparam int unsigned DWID  = 8;
  localparam int unsigned NSEG  = 13;
  localparam int unsigned VTWID = 130;
  localparam int unsigned CWID  = 4;
  localparam int          NVEC  = 10;

  typedef struct {
    logic [VTWID-1:0] vec;
    logic             match;
    logic             conflict;
    logic [DWID-1:0]  id;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [VTWID-1:0] in_vec = '0;
  logic             out_vld;
  logic             out_rdy = 1'b1;
  logic             out_match;
  logic             out_conflict;
  logic [DWID-1:0]  out_id;
  logic             cnt_clr = 1'b0;
  logic [CWID-1:0]  hit_cnt;
  logic [CWID-1:0]  miss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl [NVEC];

  segvect_match_resolver #(.CWID(CWID)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_vec       (in_vec),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_match    (out_match),
    .out_conflict (out_conflict),
    .out_id       (out_id),
    .cnt_clr      (cnt_clr),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic m, input logic c, input logic [7:0] id);
    chk({name, ".vld"}, 32'(out_vld), 32'd1);
    chk({name, ".match"}, 32'(out_match), 32'(m));
    chk({name, ".conflict"}, 32'(out_conflict), 32'(c));
    chk({name, ".id"}, 32'(out_id), 32'(id));
  endtask

  function automatic logic [VTWID-1:0] fill(input logic [9:0] v);
    logic [VTWID-1:0] r;
    r = '0;
    for (int s = 0; s < int'(NSEG); s++) r[s*10 +: 10] = v;
    return r;
  endfunction

  function automatic logic [VTWID-1:0] set_seg(input logic [VTWID-1:0] vi, input int s,
                                                input logic [9:0] v);
    logic [VTWID-1:0] r;
    r = vi;
    r[s*10 +: 10] = v;
    return r;
  endfunction

  initial begin
    logic [VTWID-1:0] v;

    tbl[0] = '{fill(10'h100), 1'b1, 1'b0, 8'h00};
    tbl[1] = '{fill(10'h109), 1'b1, 1'b0, 8'h09};
    tbl[2] = '{set_seg(fill(10'h105), 12, 10'h000), 1'b0, 1'b0, 8'h05};
    tbl[3] = '{set_seg(fill(10'h105), 3, 10'h107), 1'b0, 1'b1, 8'h05};
    v = fill(10'h103);
    for (int s = 0; s < 5; s++) v = set_seg(v, s, 10'h200);
    tbl[4] = '{v, 1'b1, 1'b0, 8'h03};
    tbl[5] = '{fill(10'h200), 1'b0, 1'b0, 8'h00};
    // hit+wildcard covers without contributing its ID
    tbl[6] = '{set_seg(set_seg(fill(10'h107), 0, 10'h200), 5, 10'h304), 1'b1, 1'b0, 8'h07};
    tbl[7] = '{set_seg(set_seg(fill(10'h100), 0, 10'h0AB), 1, 10'h1AB), 1'b0, 1'b0, 8'hAB};
    tbl[8] = '{set_seg(fill(10'h200), 12, 10'h15A), 1'b1, 1'b0, 8'h5A};
    tbl[9] = '{set_seg(fill(10'h111), 12, 10'h112), 1'b0, 1'b1, 8'h11};

    // Reset state
    #2;
    chk("rst.in_rdy", 32'(in_rdy), 32'd1);
    chk("rst.out_vld", 32'(out_vld), 32'd0);
    chk("rst.hit", 32'(hit_cnt), 32'd0);
    chk("rst.miss", 32'(miss_cnt), 32'd0);
    #10;
    rst = 1'b1;
    tick();

    // Table: one vector at a time, checking latency and verdict
    for (int i = 0; i < NVEC; i++) begin
      in_vld = 1'b1;
      in_vec = tbl[i].vec;
      tick();
      in_vld = 1'b0;
      in_vec = '0;
      chk($sformatf("tbl%0d.lat", i), 32'(out_vld), 32'd0);
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].match, tbl[i].conflict, tbl[i].id);
      tick();
    end
    chk("tbl.hit", 32'(hit_cnt), 32'd5);
    chk("tbl.miss", 32'(miss_cnt), 32'd5);
    chk("tbl.drain", 32'(out_vld), 32'd0);

    // Stream of 4 with a 3-cycle output stall after the first result
    in_vld = 1'b1;
    in_vec = tbl[0].vec;
    tick();
    in_vec = tbl[1].vec;
    tick();
    chk_out("str.a", 1'b1, 1'b0, 8'h00);
    out_rdy = 1'b0;
    in_vec  = tbl[3].vec;
    #1;
    chk("str.in_rdy0", 32'(in_rdy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("str.hold%0d", k), 1'b1, 1'b0, 8'h00);
      chk($sformatf("str.rdy%0d", k), 32'(in_rdy), 32'd0);
      chk($sformatf("str.hit%0d", k), 32'(hit_cnt), 32'd5);
    end
    out_rdy = 1'b1;
    tick();
    chk_out("str.b", 1'b1, 1'b0, 8'h09);
    chk("str.hit_a", 32'(hit_cnt), 32'd6);
    in_vec = tbl[4].vec;
    tick();
    in_vld = 1'b0;
    in_vec = '0;
    chk_out("str.c", 1'b0, 1'b1, 8'h05);
    tick();
    chk_out("str.d", 1'b1, 1'b0, 8'h03);
    tick();
    chk("str.end_vld", 32'(out_vld), 32'd0);
    chk("str.hit", 32'(hit_cnt), 32'd8);
    chk("str.miss", 32'(miss_cnt), 32'd6);

    // Saturation: 10 more hits take hit_cnt past 15
    in_vld = 1'b1;
    in_vec = tbl[0].vec;
    for (int k = 0; k < 10; k++) tick();
    in_vld = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("sat.hit", 32'(hit_cnt), 32'd15);
    chk("sat.miss", 32'(miss_cnt), 32'd6);

    // Clear wins over a simultaneous hit handshake
    in_vld = 1'b1;
    in_vec = tbl[1].vec;
    tick();
    in_vld = 1'b0;
    tick();
    chk_out("clr.res", 1'b1, 1'b0, 8'h09);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr.hit", 32'(hit_cnt), 32'd0);
    chk("clr.miss", 32'(miss_cnt), 32'd0);

    // One miss so reset clearing of miss_cnt is observable
    in_vld = 1'b1;
    in_vec = tbl[5].vec;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    chk("pre_rst.miss", 32'(miss_cnt), 32'd1);

    // Reset with two vectors in flight
    in_vld = 1'b1;
    in_vec = tbl[1].vec;
    tick();
    in_vec = tbl[4].vec;
    tick();
    in_vld = 1'b0;
    chk_out("rstf.pre", 1'b1, 1'b0, 8'h09);
    rst = 1'b0;
    #1;
    chk("rstf.vld", 32'(out_vld), 32'd0);
    chk("rstf.match", 32'(out_match), 32'd0);
    chk("rstf.id", 32'(out_id), 32'd0);
    chk("rstf.miss", 32'(miss_cnt), 32'd0);
    chk("rstf.in_rdy", 32'(in_rdy), 32'd1);
    tick();
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rstf.idle%0d", k), 32'(out_vld), 32'd0);
    end
    in_vld = 1'b1;
    in_vec = tbl[8].vec;
    tick();
    in_vld = 1'b0;
    chk("rstf.lat", 32'(out_vld), 32'd0);
    tick();
    chk_out("rstf.new", 1'b1, 1'b0, 8'h5A);
    tick();
    chk("rstf.hit", 32'(hit_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
